// File: rtl/control_sequencer_pkg.sv
// ============================================================================
// Module : cpuConfig (package)
// Brief  : Shared CPU configuration: widths, instruction field offsets,
//          ALU function, opcode and sequencer state encodings, decode helpers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpuConfig;

  localparam int CFG_N       = 8;
  localparam int CFG_R_SIZE  = 3;
  localparam int CFG_PC_SIZE = 6;
  localparam int OPC_W       = 4;
  localparam int CFG_I_WIDTH = OPC_W + 2 * CFG_R_SIZE + CFG_N;

  // Instruction layout, MSB first: opcode | rd | rs | imm
  localparam int IMM_LSB = 0;
  localparam int RS_LSB  = CFG_N;
  localparam int RD_LSB  = CFG_N + CFG_R_SIZE;
  localparam int OPC_LSB = CFG_N + 2 * CFG_R_SIZE;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_MUL   = 3'd2,
    ALU_PASSB = 3'd3
  } aluFunc_t;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_ADD    = 4'h1,
    OP_ADDI   = 4'h2,
    OP_SUB    = 4'h3,
    OP_SUBI   = 4'h4,
    OP_MUL    = 4'h5,
    OP_MULI   = 4'h6,
    OP_MOV    = 4'h7,
    OP_LDI    = 4'h8,
    OP_INSW   = 4'h9,
    OP_BZ     = 4'hA,
    OP_BNZ    = 4'hB,
    OP_JMP    = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_HALT   = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_FETCH        = 3'd0,
    ST_EXEC         = 3'd1,
    ST_WAIT_PRESS   = 3'd2,
    ST_WAIT_RELEASE = 3'd3,
    ST_WRITE_SW     = 3'd4,
    ST_HALT         = 3'd5
  } state_t;

  // Instructions that write the register file during their EXEC cycle
  function automatic logic op_writes(opcode_t op);
    logic w;
    w = 1'b0;
    case (op)
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI,
      OP_MUL, OP_MULI, OP_MOV, OP_LDI: w = 1'b1;
      default:                         w = 1'b0;
    endcase
    return w;
  endfunction

  // Instructions whose ALU B operand is the immediate field
  function automatic logic op_uses_imm(opcode_t op);
    logic u;
    u = 1'b0;
    case (op)
      OP_ADDI, OP_SUBI, OP_MULI, OP_LDI: u = 1'b1;
      default:                           u = 1'b0;
    endcase
    return u;
  endfunction

  // ALU operation selected by each opcode; non-ALU opcodes park on ADD
  function automatic aluFunc_t op_alu_func(opcode_t op);
    aluFunc_t f;
    f = ALU_ADD;
    case (op)
      OP_ADD, OP_ADDI:        f = ALU_ADD;
      OP_SUB, OP_SUBI:        f = ALU_SUB;
      OP_MUL, OP_MULI:        f = ALU_MUL;
      OP_MOV, OP_LDI:         f = ALU_PASSB;
      default:                f = ALU_ADD;
    endcase
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_sequencer_program_counter.sv
// ============================================================================
// Module : program_counter
// Brief  : Program counter register; load (branch target) beats increment,
//          arithmetic wraps modulo 2^PC_SIZE.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_counter #(
  parameter int PC_SIZE = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               load,
  input  logic [PC_SIZE-1:0] target,
  output logic [PC_SIZE-1:0] pc
);

  logic [PC_SIZE-1:0] pc_q;
  logic [PC_SIZE-1:0] pc_d;

  // Next PC: taken branch target first, otherwise sequential step
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = target;
    end else if (inc) begin
      pc_d = pc_q + {{(PC_SIZE-1){1'b0}}, 1'b1};
    end
  end

  // PC register with synchronous reset to address 0
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module : control_sequencer
// Brief  : Fetch/decode sequencer: PC, instruction register, zero flag,
//          branch handling, HALT and a press/release switch-read handshake.
//          Optional build macro SINGLE_STEP_EN adds a 'step' input that gates
//          each FETCH on a rising edge of step.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer
  import cpuConfig::*;
#(
  parameter int N       = CFG_N,
  parameter int R_SIZE  = CFG_R_SIZE,
  parameter int PC_SIZE = CFG_PC_SIZE,
  parameter int I_WIDTH = 4 + 2 * R_SIZE + N
) (
  input  logic               clk,
  input  logic               reset,
`ifdef SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic [PC_SIZE-1:0] progAddr,
  input  logic [I_WIDTH-1:0] progData,
  input  logic [N-1:0]       aluResult,
  input  logic               go,
  output logic               writeReg,
  output aluFunc_t           aluFunc,
  output logic               aluImmediate,
  output logic               immSwitches,
  output logic [R_SIZE-1:0]  opD,
  output logic [R_SIZE-1:0]  opS,
  output logic [N-1:0]       opT,
  output logic               halted
);

  state_t             state_q;
  logic [I_WIDTH-1:0] ir_q;
  logic               z_q;
  logic               writeReg_q;
  aluFunc_t           aluFunc_q;
  logic               aluImm_q;
  logic               immSw_q;
  logic               halted_q;

  logic [PC_SIZE-1:0] pc;
  opcode_t            ir_op;
  opcode_t            fetch_op;
  logic               fetch_go;
  logic               branch_taken;
  logic               pc_inc;

  assign ir_op    = opcode_t'(ir_q[OPC_LSB +: 4]);
  assign fetch_op = opcode_t'(progData[OPC_LSB +: 4]);

  // Operand fields come straight from the instruction register
  assign opD = ir_q[RD_LSB +: R_SIZE];
  assign opS = ir_q[RS_LSB +: R_SIZE];
  assign opT = ir_q[IMM_LSB +: N];

`ifdef SINGLE_STEP_EN
  logic step_prev_q;

  // Previous step level for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= step;
    end
  end

  assign fetch_go = step & ~step_prev_q;
`else
  assign fetch_go = 1'b1;
`endif

  // Branch resolution and PC sequencing, valid only while executing
  always_comb begin
    branch_taken = 1'b0;
    pc_inc       = 1'b0;
    if (state_q == ST_EXEC) begin
      case (ir_op)
        OP_BZ:   branch_taken = z_q;
        OP_BNZ:  branch_taken = ~z_q;
        OP_JMP:  branch_taken = 1'b1;
        default: branch_taken = 1'b0;
      endcase
      pc_inc = ~branch_taken && (ir_op != OP_INSW) && (ir_op != OP_HALT);
    end else if (state_q == ST_WRITE_SW) begin
      pc_inc = 1'b1;
    end
  end

  program_counter #(
    .PC_SIZE (PC_SIZE)
  ) u_pc (
    .clk    (clk),
    .reset  (reset),
    .inc    (pc_inc),
    .load   (branch_taken),
    .target (ir_q[IMM_LSB +: PC_SIZE]),
    .pc     (pc)
  );

  // Sequencer FSM; controls are registered and set on entry to the state
  // in which they are meant to be visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      ir_q       <= '0;
      z_q        <= 1'b0;
      writeReg_q <= 1'b0;
      aluFunc_q  <= ALU_ADD;
      aluImm_q   <= 1'b0;
      immSw_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      // Zero flag tracks the result of whatever was written this cycle
      if (writeReg_q) begin
        z_q <= (aluResult == '0);
      end
      writeReg_q <= 1'b0;
      aluFunc_q  <= ALU_ADD;
      aluImm_q   <= 1'b0;
      immSw_q    <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          if (fetch_go) begin
            ir_q       <= progData;
            state_q    <= ST_EXEC;
            writeReg_q <= op_writes(fetch_op);
            aluFunc_q  <= op_alu_func(fetch_op);
            aluImm_q   <= op_uses_imm(fetch_op);
          end
        end
        ST_EXEC: begin
          case (ir_op)
            OP_INSW: state_q <= ST_WAIT_PRESS;
            OP_HALT: begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end
            default: state_q <= ST_FETCH;
          endcase
        end
        ST_WAIT_PRESS: begin
          if (go) begin
            state_q <= ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (!go) begin
            state_q    <= ST_WRITE_SW;
            writeReg_q <= 1'b1;
            aluFunc_q  <= ALU_PASSB;
            aluImm_q   <= 1'b1;
            immSw_q    <= 1'b1;
          end
        end
        ST_WRITE_SW: begin
          state_q <= ST_FETCH;
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  assign progAddr     = pc;
  assign writeReg     = writeReg_q;
  assign aluFunc      = aluFunc_q;
  assign aluImmediate = aluImm_q;
  assign immSwitches  = immSw_q;
  assign halted       = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module : tb_control_sequencer
// Brief  : Directed bench with ROM, register file and ALU models; register
//          writes are checked against an expected-write queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;
  import cpuConfig::*;

  logic        clk;
  logic        reset;
  logic        go;
  logic [5:0]  progAddr;
  logic [17:0] progData;
  logic [7:0]  aluResult;
  logic        writeReg;
  aluFunc_t    aluFunc;
  logic        aluImmediate;
  logic        immSwitches;
  logic [2:0]  opD;
  logic [2:0]  opS;
  logic [7:0]  opT;
  logic        halted;
`ifdef SINGLE_STEP_EN
  logic        step;
`endif

  logic [17:0] rom [64];
  logic [7:0]  regs [8];
  logic [7:0]  sw;
  logic [7:0]  alu_b;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] val;
  } wr_t;
  wr_t exp_q[$];

  int total;
  int bad;

  control_sequencer dut (
    .clk          (clk),
    .reset        (reset),
`ifdef SINGLE_STEP_EN
    .step         (step),
`endif
    .progAddr     (progAddr),
    .progData     (progData),
    .aluResult    (aluResult),
    .go           (go),
    .writeReg     (writeReg),
    .aluFunc      (aluFunc),
    .aluImmediate (aluImmediate),
    .immSwitches  (immSwitches),
    .opD          (opD),
    .opS          (opS),
    .opT          (opT),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign progData = rom[progAddr];

  // ALU / data-path model
  always_comb begin
    alu_b = aluImmediate ? (immSwitches ? sw : opT) : regs[opS];
    case (aluFunc)
      ALU_ADD:   aluResult = regs[opD] + alu_b;
      ALU_SUB:   aluResult = regs[opD] - alu_b;
      ALU_MUL:   aluResult = 8'(regs[opD] * alu_b);
      ALU_PASSB: aluResult = alu_b;
      default:   aluResult = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (writeReg === 1'b1) regs[opD] <= aluResult;
  end

  function automatic logic [17:0] ins(logic [3:0] op, logic [2:0] rd,
                                      logic [2:0] rs, logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic push(logic [2:0] rd, logic [7:0] val);
    wr_t e;
    e.rd  = rd;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = ins(4'h0, 3'd0, 3'd0, 8'h00);
  endtask

  // Scoreboard: every register write must match the next expected write
  always @(negedge clk) begin
    if (reset === 1'b0 && writeReg === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected_write observed rd=%0d val=%0h expected=none", opD, aluResult);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_rd", 32'(opD), 32'(e.rd));
        chk("sb_val", 32'(aluResult), 32'(e.val));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    go    = 1'b0;
    sw    = 8'hA5;
`ifdef SINGLE_STEP_EN
    step  = 1'b0;
`endif
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    clear_rom();

`ifdef SINGLE_STEP_EN
    rom[0] = ins(4'h8, 3'd1, 3'd0, 8'h07);
    rom[1] = ins(4'h8, 3'd2, 3'd0, 8'h09);
    push(3'd1, 8'h07);
    do_reset();
    chk("ss_rst_pc", 32'(progAddr), 32'd0);
    step = 1'b1;
    tick(10);
    chk("ss_hold_pc", 32'(progAddr), 32'd1);
    chk("ss_one_write", 32'(exp_q.size()), 32'd0);
    step = 1'b0;
    tick();
    push(3'd2, 8'h09);
    step = 1'b1;
    tick();
    chk("ss2_wr", 32'(writeReg), 32'd1);
    tick(5);
    chk("ss2_pc", 32'(progAddr), 32'd2);
    chk("ss_sb_empty", 32'(exp_q.size()), 32'd0);
`else
    // ---------------- Phase A: ALU ops, branches, INSW, wrap ----------------
    rom[8'h00] = ins(4'h8, 3'd1, 3'd0, 8'h03);   // LDI  r1,#3
    rom[8'h01] = ins(4'h2, 3'd1, 3'd0, 8'hFD);   // ADDI r1,#FD
    rom[8'h02] = ins(4'hA, 3'd0, 3'd0, 8'h20);   // BZ   #20
    rom[8'h20] = ins(4'hB, 3'd0, 3'd0, 8'h30);   // BNZ  #30
    rom[8'h21] = ins(4'h9, 3'd2, 3'd0, 8'h00);   // INSW r2
    rom[8'h22] = ins(4'h7, 3'd3, 3'd2, 8'h00);   // MOV  r3,r2
    rom[8'h23] = ins(4'h4, 3'd3, 3'd0, 8'h01);   // SUBI r3,#1
    rom[8'h24] = ins(4'hC, 3'd0, 3'd0, 8'h3F);   // JMP  #3F
    rom[8'h3F] = ins(4'h0, 3'd0, 3'd0, 8'h00);   // NOP
    push(3'd1, 8'h03);
    push(3'd1, 8'h00);
    push(3'd2, 8'hA5);
    push(3'd3, 8'hA5);
    push(3'd3, 8'hA4);

    do_reset();
    chk("rst_pc", 32'(progAddr), 32'd0);
    chk("rst_wr", 32'(writeReg), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_imm", 32'(aluImmediate), 32'd0);
    chk("rst_isw", 32'(immSwitches), 32'd0);
    chk("rst_func", 32'(aluFunc), 32'(ALU_ADD));

    tick();                                        // EXEC LDI
    chk("ldi_wr", 32'(writeReg), 32'd1);
    chk("ldi_func", 32'(aluFunc), 32'(ALU_PASSB));
    chk("ldi_opT", 32'(opT), 32'h03);
    chk("ldi_imm", 32'(aluImmediate), 32'd1);
    tick();                                        // FETCH 1
    chk("f1_wr", 32'(writeReg), 32'd0);
    chk("f1_pc", 32'(progAddr), 32'd1);
    tick();                                        // EXEC ADDI
    chk("addi_wr", 32'(writeReg), 32'd1);
    chk("addi_func", 32'(aluFunc), 32'(ALU_ADD));
    chk("addi_opT", 32'(opT), 32'hFD);
    tick(2);                                       // EXEC BZ
    chk("bz_wr", 32'(writeReg), 32'd0);
    tick();
    chk("bz_taken_pc", 32'(progAddr), 32'h20);
    tick(2);
    chk("bnz_not_taken_pc", 32'(progAddr), 32'h21);

    go = 1'b1;                                     // already pressed at entry
    tick(3);                                       // EXEC, WAIT_PRESS, WAIT_RELEASE
    for (int i = 0; i < 4; i++) begin
      chk("insw_hold_wr", 32'(writeReg), 32'd0);
      tick();
    end
    go = 1'b0;
    tick();                                        // WRITE_SW
    go = 1'b1;
    chk("sw_wr", 32'(writeReg), 32'd1);
    chk("sw_isw", 32'(immSwitches), 32'd1);
    chk("sw_imm", 32'(aluImmediate), 32'd1);
    chk("sw_opD", 32'(opD), 32'd2);
    chk("sw_func", 32'(aluFunc), 32'(ALU_PASSB));
    tick();
    chk("sw_once_wr", 32'(writeReg), 32'd0);
    chk("sw_next_pc", 32'(progAddr), 32'h22);
    go = 1'b0;

    tick();                                        // EXEC MOV
    chk("mov_imm", 32'(aluImmediate), 32'd0);
    chk("mov_func", 32'(aluFunc), 32'(ALU_PASSB));
    tick(4);                                       // ..SUBI, JMP EXEC
    tick();
    chk("jmp_pc", 32'(progAddr), 32'h3F);
    tick(2);
    chk("wrap_pc", 32'(progAddr), 32'd0);
    chk("sbA_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- Phase B: reset mid-wait, HALT ----------------
    reset = 1'b1;
    clear_rom();
    rom[5] = ins(4'h9, 3'd2, 3'd0, 8'h00);         // INSW r2
    rom[7] = ins(4'hF, 3'd0, 3'd0, 8'h00);         // HALT
    do_reset();
    go = 1'b1;
    tick(10);
    chk("b_pc5", 32'(progAddr), 32'd5);
    tick(3);                                       // now in WAIT_RELEASE
    do_reset();
    chk("mid_rst_pc", 32'(progAddr), 32'd0);
    chk("mid_rst_wr", 32'(writeReg), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    go = 1'b0;
    push(3'd2, 8'hA5);
    tick(10);
    tick(3);                                       // EXEC, WAIT_PRESS, stays
    chk("wp_wait_wr", 32'(writeReg), 32'd0);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();                                        // WRITE_SW
    chk("b_sw_wr", 32'(writeReg), 32'd1);
    tick(5);                                       // FETCH6, EXEC, FETCH7, EXEC HALT, HALT
    for (int i = 0; i < 20; i++) begin
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_pc", 32'(progAddr), 32'd7);
      chk("halt_wr", 32'(writeReg), 32'd0);
      tick();
    end
    do_reset();
    chk("post_halt_flag", 32'(halted), 32'd0);
    chk("post_halt_pc", 32'(progAddr), 32'd0);
    chk("sbB_empty", 32'(exp_q.size()), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
